// File: rtl/cpu_run_ctrl.sv
// Run controller: resets, starts and watches one core through a program run,
// latches its result and cycle count, and completes the done/ack handshake.
// Ports: clk, reset (sync, active-low), go/abort/auto_mode board requests,
//   cpu_done/cpu_ld from the core, cpu_reset/cpu_start/cpu_ack to the core,
//   busy/result/cycles/timeout/run_count/done_pulse registered status.
module cpu_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic             auto_mode,
  input  logic             cpu_done,
  input  logic [7:0]       cpu_ld,
  output logic             cpu_reset,
  output logic             cpu_start,
  output logic             cpu_ack,
  output logic             busy,
  output logic [7:0]       result,
  output logic [CNT_W-1:0] cycles,
  output logic             timeout,
  output logic [7:0]       run_count,
  output logic             done_pulse
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_RUN,
    S_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             cpu_start_q, cpu_start_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             busy_q, busy_d;
  logic [7:0]       result_q, result_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       run_count_q, run_count_d;
  logic             done_pulse_q, done_pulse_d;

  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    cycles_d     = cycles_q;
    timeout_d    = timeout_q;
    run_count_d  = run_count_q;
    done_pulse_d = 1'b0;

    if (abort) begin
      // abort wins over everything but reset and leaves results untouched
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go || auto_mode) begin
            timeout_d = 1'b0;
            rcnt_d    = '0;
            state_d   = S_CLR;
          end
        end
        S_CLR: begin
          if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
            state_d = S_START;
          end else begin
            rcnt_d = rcnt_q + RCW'(1);
          end
        end
        S_START: begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (cpu_done) begin
            result_d = cpu_ld;
            cycles_d = cnt_q;
            state_d  = S_ACK;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
            cycles_d  = CNT_W'(TIMEOUT);
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_ACK: begin
          if (!cpu_done) begin
            run_count_d  = run_count_q + 8'd1;
            done_pulse_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // core-facing outputs are registered copies of the next state's decode
    cpu_reset_d = (state_d == S_IDLE) || (state_d == S_CLR);
    cpu_start_d = (state_d == S_START);
    cpu_ack_d   = (state_d == S_ACK);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rcnt_q       <= '0;
      cnt_q        <= '0;
      cpu_reset_q  <= 1'b1;
      cpu_start_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      result_q     <= '0;
      cycles_q     <= '0;
      timeout_q    <= 1'b0;
      run_count_q  <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      cnt_q        <= cnt_d;
      cpu_reset_q  <= cpu_reset_d;
      cpu_start_q  <= cpu_start_d;
      cpu_ack_q    <= cpu_ack_d;
      busy_q       <= busy_d;
      result_q     <= result_d;
      cycles_q     <= cycles_d;
      timeout_q    <= timeout_d;
      run_count_q  <= run_count_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign cpu_start  = cpu_start_q;
  assign cpu_ack    = cpu_ack_q;
  assign busy       = busy_q;
  assign result     = result_q;
  assign cycles     = cycles_q;
  assign timeout    = timeout_q;
  assign run_count  = run_count_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: timeline model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_cpu_run_ctrl;

  localparam int RST = 2;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        auto_mode = 1'b0;
  logic        cpu_done = 1'b0;
  logic [7:0]  cpu_ld = 8'h00;
  logic        cpu_reset, cpu_start, cpu_ack, busy, timeout, done_pulse;
  logic [7:0]  result, run_count;
  logic [15:0] cycles;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RST_CYCLES(RST), .CNT_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .auto_mode(auto_mode), .cpu_done(cpu_done), .cpu_ld(cpu_ld),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start), .cpu_ack(cpu_ack),
    .busy(busy), .result(result), .cycles(cycles), .timeout(timeout),
    .run_count(run_count), .done_pulse(done_pulse)
  );

  int pass_n = 0;
  int total_n = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // core stand-in: done raised core_lat RUN cycles after start, held core_hold
  int         core_lat = 0;
  int         core_hold = 1;
  logic [7:0] core_ld = 8'h00;

  initial begin
    int  ccnt;
    int  hleft;
    bit  armed;
    ccnt = 0; hleft = 0; armed = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cpu_reset) begin
        cpu_done = 1'b0; armed = 1'b0; ccnt = 0;
      end else if (cpu_start) begin
        cpu_done = 1'b0; armed = 1'b1; ccnt = 0;
      end else if (armed) begin
        if (core_lat >= 0 && ccnt == core_lat) begin
          cpu_done = 1'b1; cpu_ld = core_ld;
          armed = 1'b0; hleft = core_hold;
        end else begin
          ccnt++;
        end
      end else if (cpu_done) begin
        hleft--;
        if (hleft <= 0) cpu_done = 1'b0;
      end
    end
  end

  // timeline model: a run accepted at edge a owns CLR cycles a..a+RST-1,
  // START at a+RST, and RUN cycle k at a+RST+1+k
  int          ec = 0;
  bit          m_busy = 0, m_ack = 0;
  int          m_a = 0;
  logic [7:0]  m_res = 0, m_rc = 0;
  logic [15:0] m_cy = 0;
  bit          m_to = 0, m_pulse = 0;
  bit          e_rst = 1, e_start = 0, e_ack = 0;

  always @(posedge clk) begin : model
    automatic int   e = ec + 1;
    automatic bit   b = m_busy;
    automatic bit   k = m_ack;
    automatic int   a = m_a;
    automatic logic [7:0]  res = m_res;
    automatic logic [7:0]  rc = m_rc;
    automatic logic [15:0] cy = m_cy;
    automatic bit   to = m_to;
    automatic bit   p = 1'b0;
    automatic int   rel;
    if (!reset) begin
      b = 0; k = 0; res = 0; cy = 0; to = 0; rc = 0;
    end else if (abort) begin
      b = 0; k = 0;
    end else if (!b) begin
      if (go || auto_mode) begin
        to = 0; b = 1; a = e;
      end
    end else if (k) begin
      if (!cpu_done) begin
        b = 0; k = 0; rc = rc + 8'd1; p = 1;
      end
    end else begin
      rel = ec - a;
      if (rel > RST) begin
        if (cpu_done) begin
          res = cpu_ld; cy = 16'(rel - RST - 1); k = 1;
        end else if (rel - RST - 1 == TO) begin
          to = 1; cy = 16'(TO); b = 0;
        end
      end
    end
    rel = e - a;
    ec      <= e;
    m_busy  <= b;
    m_ack   <= k;
    m_a     <= a;
    m_res   <= res;
    m_rc    <= rc;
    m_cy    <= cy;
    m_to    <= to;
    m_pulse <= p;
    e_rst   <= !b || (!k && rel < RST);
    e_start <= b && !k && rel == RST;
    e_ack   <= b && k;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_model",
          {cpu_reset, cpu_start, cpu_ack, busy, timeout, done_pulse,
           result, cycles, run_count},
          {e_rst, e_start, e_ack, m_busy, m_to, m_pulse,
           m_res, m_cy, m_rc});
    end
  end

  initial begin
    int t;
    int starts;
    int np;
    int ts[3];
    bit seen_ack;
    bit bad;

    // reset
    reset = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_outs", {cpu_start, cpu_ack, busy, timeout, done_pulse}, 0);
    chk("rst_regs", {result, cycles, run_count}, 0);
    reset = 1'b1;
    cyc();

    // nominal run
    core_lat = 10; core_hold = 3; core_ld = 8'hA5;
    go = 1'b1;
    cyc();
    go = 1'b0;
    t = 1;
    while (!cpu_start && t < 20) begin
      cyc();
      t++;
    end
    chk("go_to_start", t, 3);
    starts = 1; seen_ack = 0; t = 0;
    while (!done_pulse && t < 100) begin
      cyc();
      t++;
      if (cpu_start) starts++;
      if (cpu_ack && !seen_ack) begin
        seen_ack = 1;
        chk("nom_result", result, 8'hA5);
        chk("nom_cycles", cycles, 10);
      end
    end
    chk("nom_pulse_seen", done_pulse, 1);
    chk("nom_starts", starts, 1);
    chk("nom_run_count", run_count, 1);
    cyc();
    chk("nom_pulse_once", done_pulse, 0);

    // timeout
    core_lat = -1;
    go = 1'b1;
    cyc();
    go = 1'b0;
    t = 0;
    while (busy && t < 60) begin
      cyc();
      t++;
    end
    chk("to_idle", busy, 0);
    chk("to_flag", timeout, 1);
    chk("to_cycles", cycles, 20);
    chk("to_result", result, 8'hA5);
    chk("to_run_count", run_count, 1);
    core_lat = 3; core_hold = 1; core_ld = 8'h5A;
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("to_cleared", timeout, 0);
    t = 0;
    while (!done_pulse && t < 60) begin
      cyc();
      t++;
    end
    chk("run2_count", run_count, 2);

    // abort in RUN, with an ignored go
    core_lat = -1;
    cyc();
    go = 1'b1;
    cyc();
    go = 1'b0;
    repeat (6) cyc();
    go = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_idle", {busy, cpu_reset, done_pulse}, 3'b010);
    bad = 0;
    repeat (10) begin
      cyc();
      if (busy || done_pulse) bad = 1;
    end
    chk("abort_no_rerun", bad, 0);
    chk("abort_regs", {result, cycles, run_count}, {8'h5A, 16'd3, 8'd2});

    // auto mode, three runs
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    core_lat = 5; core_hold = 1;
    auto_mode = 1'b1;
    np = 0; t = 0;
    while (np < 3 && t < 200) begin
      cyc();
      t++;
      if (done_pulse) begin
        ts[np] = t;
        np++;
        if (np == 3) auto_mode = 1'b0;
      end
    end
    auto_mode = 1'b0;
    chk("auto_pulses", np, 3);
    chk("auto_gap1", ts[1] - ts[0], 5 + RST + 4);
    chk("auto_gap2", ts[2] - ts[1], 5 + RST + 4);
    chk("auto_run_count", run_count, 3);
    cyc();
    chk("auto_stop", busy, 0);

    // 256 runs wrap run_count
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    core_lat = 0; core_hold = 1;
    auto_mode = 1'b1;
    np = 0; t = 0;
    while (np < 256 && t < 2000) begin
      cyc();
      t++;
      if (done_pulse) begin
        np++;
        if (np == 256) auto_mode = 1'b0;
      end
    end
    auto_mode = 1'b0;
    chk("wrap_pulses", np, 256);
    chk("wrap_run_count", run_count, 0);

    // reset during ACK
    core_lat = 2; core_hold = 10; core_ld = 8'h3C;
    cyc();
    go = 1'b1;
    cyc();
    go = 1'b0;
    t = 0;
    while (!cpu_ack && t < 40) begin
      cyc();
      t++;
    end
    cyc();
    chk("ack_held", cpu_ack, 1);
    chk("ack_regs", {result, cycles}, {8'h3C, 16'd2});
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("ackrst_outs",
        {cpu_reset, cpu_start, cpu_ack, busy, timeout, done_pulse},
        6'b100000);
    chk("ackrst_regs", {result, cycles, run_count}, 0);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sequences one `CpuHardcoded` core through a complete program execution. It holds the core in reset, issues the `start` pulse, and watches `done` against a cycle watchdog. It then latches the `ld` result and cycle count, and completes the `done`/`ack` handshake. It sits between board-level controls (debounced button pulses) and the core, and provides registered status for the LEDs and seven-segment display.

## Interface
Parameters:
- `RST_CYCLES`, default 2: number of cycles the core is held in reset before each run (≥1).
- `CNT_W`, default 16: width of the cycle counter and the `cycles` output.
- `TIMEOUT`, default 50000: maximum RUN cycles before the run is aborted (must be < 2^CNT_W).

Ports:
- `clk` in 1: single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-low. `reset`=0 sampled at a rising edge forces all state to reset values.
- `go` in 1: one-cycle run request. Accepted only in IDLE.
- `abort` in 1: forces return to IDLE from any state.
- `auto_mode` in 1: when 1, IDLE restarts a run automatically, with no `go` needed.
- `cpu_done` in 1: core `done` output.
- `cpu_ld` in 8: core `ld` output.
- `cpu_reset` out 1: active-high reset to the core.
- `cpu_start` out 1: core `start` input.
- `cpu_ack` out 1: core `ack` input.
- `busy` out 1: 1 in any state other than IDLE.
- `result` out 8: `cpu_ld` latched when the run finished.
- `cycles` out CNT_W: RUN-cycle count of the last finished or timed-out run.
- `timeout` out 1: sticky flag; the last run hit `TIMEOUT`.
- `run_count` out 8: number of successfully completed runs; wraps 255→0.
- `done_pulse` out 1: one-cycle strobe when a run completes.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE;
  - `cpu_reset`=1;
  - `cpu_start`=`cpu_ack`=`busy`=`timeout`=`done_pulse`=0;
  - `result`=0, `cycles`=0, `run_count`=0.
- States:
  - IDLE: `cpu_reset`=1. If (`go` | `auto_mode`) & !`abort`, clear `timeout` and go to CLR.
  - CLR: `cpu_reset`=1 for exactly `RST_CYCLES` cycles (internal counter), then go to START.
  - START: `cpu_reset`=0, `cpu_start`=1 for exactly one cycle. Cycle counter is cleared to 0. Next state is RUN.
  - RUN: `cpu_start`=0.
    - If `cpu_done`=1: latch `result`←`cpu_ld` and `cycles`←counter, then go to ACK.
    - Else if counter == `TIMEOUT`: set `timeout`=1, latch `cycles`←`TIMEOUT`, then go to IDLE. `result` and `run_count` are unchanged.
    - Else: counter increments by 1.
  - ACK: `cpu_ack`=1 while `cpu_done`=1. On the first cycle with `cpu_done`=0, go to IDLE, `cpu_ack`←0, `run_count`+1 (mod 256), `done_pulse`=1 for one cycle. There is no ACK watchdog; the controller waits indefinitely.
- Priority, highest first: `reset` > `abort` > `cpu_done` > timeout > `go`/`auto_mode`.
- `abort` in any state: next state IDLE, `cpu_reset`=1 next cycle, `cpu_start`=`cpu_ack`=0. `result`, `cycles` and `run_count` are untouched; no `done_pulse`.
- `go` outside IDLE is ignored; it is not queued.
- The counter is CNT_W bits. With `TIMEOUT` < 2^CNT_W the counter never wraps.

## Timing
- `go`=1 in IDLE at edge n:
  - CLR during cycles n+1 … n+`RST_CYCLES`;
  - `cpu_start`=1 and `cpu_reset`=0 at cycle n+`RST_CYCLES`+1;
  - RUN from n+`RST_CYCLES`+2.
- `cycles` = number of RUN cycles in which `cpu_done` was sampled 0. Done seen on the first RUN cycle gives `cycles`=0.
- `result`/`cycles` are valid from the cycle after `cpu_done` is sampled 1. `cpu_ack` rises that same cycle.
- `done_pulse` is high for the single cycle in which state returns to IDLE from ACK.
- Auto mode: the next CLR begins the cycle after `done_pulse` (IDLE lasts one cycle).
- Timeout: sampled at the RUN cycle where counter == `TIMEOUT`. `cpu_reset`=1 and `timeout`=1 the following cycle.
- `reset`=0 mid-run: all outputs take reset values at the next edge. `cpu_reset`=1 immediately after, so the core is also reset.

## Test plan
- Reset: hold `reset`=0 for 2 cycles → `cpu_reset`=1, all other outputs 0; `busy`=0.
- Nominal run (`RST_CYCLES`=2): `go` pulse; core model raises `cpu_done` 10 RUN cycles after `cpu_start` with `cpu_ld`=8'hA5.
  - `cpu_start` is high exactly once, 3 cycles after `go`.
  - `result`=8'hA5, `cycles`=10, `cpu_ack`=1 until `cpu_done` falls.
  - Then `done_pulse` for 1 cycle and `run_count`=1.
- Timeout (`TIMEOUT`=20): core never raises `cpu_done`.
  - `timeout`=1 and `cycles`=20, back in IDLE.
  - `result` is unchanged and `run_count` is unchanged.
  - A following `go` clears `timeout`.
- Abort and ignored request: `abort` in RUN → IDLE next cycle, `cpu_reset`=1, no `done_pulse`. A `go` issued during RUN produces no second run.
- Auto mode: `auto_mode`=1 for 3 runs with `cpu_done` after 5 cycles → `run_count`=3, consecutive `done_pulse`s spaced 5+`RST_CYCLES`+4 cycles apart.
- Wrap and reset: 256 completed runs → `run_count`=0. `reset`=0 asserted during ACK → all outputs return to reset values next cycle.
